// File: rtl/sumador_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Optional SUMADOR_OVERFLOW_EN adds a signed-overflow flag (see sumador_serial).
package sumador_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sumador_state_t;

    localparam int SUMADOR_WIDTH_DEF = 4;

endpackage

// File: rtl/sumador_if.sv
// Request/result bundle for the bit-serial adder.
// Ovf exists only when SUMADOR_OVERFLOW_EN is defined.
interface sumador_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef SUMADOR_OVERFLOW_EN
    logic             Ovf;
`endif

    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout
`ifdef SUMADOR_OVERFLOW_EN
        , input Ovf
`endif
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout
`ifdef SUMADOR_OVERFLOW_EN
        , output Ovf
`endif
    );

endinterface

// File: rtl/sumador_completo.sv
// Combinational 1-bit full adder cell used by the serial adder datapath.
module sumador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial adder: LSB-first through one full-adder cell, one bit per clock.
// Define SUMADOR_OVERFLOW_EN to add the registered signed-overflow output Ovf.
module sumador_serial
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH = SUMADOR_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    sumador_if.slave   bus
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam int unsigned ResW = WIDTH - 1;

    sumador_state_t   state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // Holds the WIDTH-1 low bits already produced; the final bit comes straight from the cell.
    logic [ResW-1:0]  res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SUMADOR_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_c;

    sumador_completo u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SUMADOR_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = bus.Cin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CntW'(1);
                res_d   = ResW'({fa_s, res_q} >> 1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = {fa_s, res_q};
                    cout_d  = fa_c;
`ifdef SUMADOR_OVERFLOW_EN
                    // carry_q is the carry into the MSB on this last step.
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SUMADOR_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SUMADOR_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
`ifdef SUMADOR_OVERFLOW_EN
    assign bus.Ovf  = ovf_q;
`endif

endmodule
